// File: rtl/carregador_de_instrucoes.sv
// Byte-stream program loader: packs bytes big-endian into 32-bit words and
// writes them to instruction memory at consecutive word addresses from 0.
module carregador_de_instrucoes #(
    parameter int PALAVRAS = 8,
    parameter int NW       = $clog2(PALAVRAS) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] n_palavras,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          ocupado,
    output logic          concluido,
    output logic          erro
);

    // state   | meaning
    // OCIOSO  | idle, waiting for start; CPU free
    // RECEBE  | accepting bytes of the current word
    // ESCREVE | one-cycle write of the assembled word

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        RECEBE  = 2'd1,
        ESCREVE = 2'd2
    } estado_t;

    estado_t       state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [NW-1:0] word_idx_q, word_idx_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   shreg_q, shreg_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          concluido_q, concluido_d;
    logic          erro_q, erro_d;

    logic          n_ilegal;

    assign n_ilegal = (n_palavras == '0) || (n_palavras > NW'(PALAVRAS));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        concluido_d = concluido_q;
        erro_d      = erro_q;

        case (state_q)
            OCIOSO: begin
                if (start) begin
                    concluido_d = 1'b0;
                    if (n_ilegal) begin
                        erro_d = 1'b1;
                    end else begin
                        erro_d     = 1'b0;
                        n_d        = n_palavras;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        state_d    = RECEBE;
                    end
                end
            end
            RECEBE: begin
                if (byte_valid) begin
                    shreg_d    = {shreg_q[23:0], byte_in};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Address/data are registered here so they are valid
                    // exactly in the ESCREVE cycle.
                    if (byte_cnt_q == 2'd3) begin
                        addr_d  = {{(30-NW){1'b0}}, word_idx_q, 2'b00};
                        wdata_d = {shreg_q[23:0], byte_in};
                        state_d = ESCREVE;
                    end
                end
            end
            ESCREVE: begin
                if (word_idx_q == n_q - NW'(1)) begin
                    concluido_d = 1'b1;
                    state_d     = OCIOSO;
                end else begin
                    word_idx_d = word_idx_q + NW'(1);
                    state_d    = RECEBE;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= OCIOSO;
            n_q         <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            concluido_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            concluido_q <= concluido_d;
            erro_q      <= erro_d;
        end
    end

    assign byte_ready = (state_q == RECEBE);
    assign mem_we     = (state_q == ESCREVE);
    assign ocupado    = (state_q != OCIOSO);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign concluido  = concluido_q;
    assign erro       = erro_q;

endmodule

// File: tb/tb_carregador_de_instrucoes.sv
// Scoreboard bench for the program loader: expected writes are queued as
// bytes are driven and compared whenever the loader strobes mem_we.
module tb_carregador_de_instrucoes;

    localparam int PALAVRAS = 8;
    localparam int NW       = $clog2(PALAVRAS) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NW-1:0] n_palavras;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          ocupado;
    logic          concluido;
    logic          erro;

    carregador_de_instrucoes #(.PALAVRAS(PALAVRAS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_palavras (n_palavras),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .ocupado    (ocupado),
        .concluido  (concluido),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int writes   = 0;

    logic [63:0] sb_q[$];
    int          we_cycles[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [63:0] e;
            writes++;
            we_cycles.push_back(cycle);
            chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", mem_addr, e[63:32]);
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge right after the byte was consumed.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_start(input logic [NW-1:0] n);
        start      = 1'b1;
        n_palavras = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_word(input int idx, input logic [31:0] w);
        sb_q.push_back({32'(idx * 4), w});
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, {25'd0, byte_ready, mem_we, ocupado, concluido, erro, 2'd0}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_data"}, mem_wdata, 32'd0);
    endtask

    logic [31:0] prog[2];
    logic [31:0] w;
    int          base;

    initial begin
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h8C09_0004;
        reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA; n_palavras = 4'd2;

        // Reset with activity on the inputs
        @(negedge clk); @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ready_after_reset", {31'd0, byte_ready}, 32'd0);
        chk("writes_after_reset", 32'(writes), 32'd0);
        byte_valid = 1'b0;

        // Two words, streaming
        do_start(4'd2);
        chk("start_ocupado", {31'd0, ocupado}, 32'd1);
        chk("start_ready", {31'd0, byte_ready}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            push_word(k, prog[k]);
            send_word(prog[k], 1'b0);
        end
        chk("last_write_ocupado", {31'd0, ocupado}, 32'd1);
        chk("last_write_we", {31'd0, mem_we}, 32'd1);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("done_concluido", {31'd0, concluido}, 32'd1);
        chk("done_ocupado", {31'd0, ocupado}, 32'd0);
        if (we_cycles.size() >= 2)
            chk("write_spacing", 32'(we_cycles[1] - we_cycles[0]), 32'd5);
        else
            chk("write_count_stream", 32'(we_cycles.size()), 32'd2);

        // Gapped source
        base = writes;
        do_start(4'd2);
        chk("gap_concluido_clear", {31'd0, concluido}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            push_word(k, prog[k]);
            send_word(prog[k], 1'b1);
        end
        repeat (2) @(negedge clk);
        chk("gap_writes", 32'(writes - base), 32'd2);
        chk("gap_concluido", {31'd0, concluido}, 32'd1);

        // Full memory, with a start pulse mid-load
        base = writes;
        do_start(4'd8);
        for (int k = 0; k < 8; k++) begin
            w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            push_word(k, w);
            if (k == 3) begin
                start = 1'b1; n_palavras = 4'd0;
            end
            send_word(w, 1'b0);
            start = 1'b0;
        end
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("full_writes", 32'(writes - base), 32'd8);
        chk("full_erro", {31'd0, erro}, 32'd0);
        chk("full_concluido", {31'd0, concluido}, 32'd1);

        // Illegal counts
        base = writes;
        do_start(4'd0);
        chk("ill0_erro", {31'd0, erro}, 32'd1);
        chk("ill0_concluido", {31'd0, concluido}, 32'd0);
        chk("ill0_ready", {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        do_start(4'd9);
        chk("ill9_erro", {31'd0, erro}, 32'd1);
        chk("ill9_ready", {31'd0, byte_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("ill_writes", 32'(writes - base), 32'd0);
        do_start(4'd1);
        chk("legal_clears_erro", {31'd0, erro}, 32'd0);
        push_word(0, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF, 1'b0);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("one_word_concluido", {31'd0, concluido}, 32'd1);

        // Reset mid-word
        base = writes;
        do_start(4'd2);
        push_word(0, prog[0]);
        send_word(prog[0], 1'b0);
        send_byte(8'h8C, 1'b0);
        send_byte(8'h09, 1'b0);
        byte_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_writes", 32'(writes - base), 32'd1);
        do_start(4'd1);
        push_word(0, 32'h0BAD_F00D);
        send_word(32'h0BAD_F00D, 1'b0);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reload_writes", 32'(writes - base), 32'd2);
        chk("reload_concluido", {31'd0, concluido}, 32'd1);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
